// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand/command and result/status signals of the multiply-divide unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    modport master (output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
                    output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style HI/LO multiply/divide, one shift-add or restoring
// divide step per cycle, signs handled as magnitudes plus a final correction cycle.
module muldiv_unit #(parameter int XLEN = 32) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              div_q, div_d, sgn_p_q, sgn_p_d, sgn_r_q, sgn_r_d, div0_q, div0_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*XLEN-1:0] w_q, w_d;
    logic              a_neg, b_neg, ok;
    logic [XLEN-1:0]   a_mag, b_mag, quo, rem, r_new;
    logic [XLEN:0]     sum, sh, diff;
    logic [2*XLEN-1:0] prod;
    assign a_neg = bus.op[0] & bus.rs_data[XLEN-1];
    assign b_neg = bus.op[0] & bus.rt_data[XLEN-1];
    assign a_mag = a_neg ? -bus.rs_data : bus.rs_data;
    assign b_mag = b_neg ? -bus.rt_data : bus.rt_data;
    // w_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    assign sum   = {1'b0, w_q[2*XLEN-1:XLEN]} + {1'b0, w_q[0] ? b_q : {XLEN{1'b0}}};
    assign sh    = {w_q[2*XLEN-1:XLEN], w_q[XLEN-1]};
    assign diff  = sh - {1'b0, b_q};
    assign ok    = ~diff[XLEN];
    assign r_new = ok ? diff[XLEN-1:0] : sh[XLEN-1:0];
    assign quo   = w_q[XLEN-1:0];
    assign rem   = w_q[2*XLEN-1:XLEN];
    assign prod  = sgn_p_q ? -w_q : w_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sgn_p_d = sgn_p_q;
        sgn_r_d = sgn_r_q;
        div0_d  = div0_q;
        b_d     = b_q;
        w_d     = w_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = CW'(XLEN);
                    div_d   = bus.op[1];
                    sgn_p_d = a_neg ^ b_neg;
                    sgn_r_d = a_neg;
                    div0_d  = bus.op[1] & (bus.rt_data == '0);
                    b_d     = bus.op[1] ? b_mag : a_mag;
                    w_d     = {{XLEN{1'b0}}, bus.op[1] ? a_mag : b_mag};
                end else begin
                    hi_d = bus.hi_we ? bus.wdata : hi_q;
                    lo_d = bus.lo_we ? bus.wdata : lo_q;
                end
            end
            CALC: begin
                w_d     = div_q ? {r_new, w_q[XLEN-2:0], ok} : {sum, w_q[XLEN-1:1]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? FIX : CALC;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                // a zero divisor leaves |A| as remainder, so only the quotient needs forcing
                lo_d    = div_q ? (div0_q ? {XLEN{1'b1}} : (sgn_p_q ? -quo : quo)) : prod[XLEN-1:0];
                hi_d    = div_q ? (sgn_r_q ? -rem : rem) : prod[2*XLEN-1:XLEN];
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sgn_p_q <= 1'b0;
            sgn_r_q <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
            b_q     <= '0;
            w_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sgn_p_q <= sgn_p_d;
            sgn_r_q <= sgn_r_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
            b_q     <= b_d;
            w_q     <= w_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; latency and all concrete values below assume XLEN=32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port rs_data  input  XLEN  operand A (multiplicand / dividend), taken from register-file read_data1.
REQ-007 SHALL have port rt_data  input  XLEN  operand B (multiplier / divisor), taken from register-file read_data2.
REQ-008 SHALL have port hi_we  input  1  MTHI strobe.
REQ-009 SHALL have port lo_we  input  1  MTLO strobe.
REQ-010 SHALL have port wdata  input  XLEN  MTHI/MTLO data.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port hi  output  XLEN  HI register (product upper half / remainder).
REQ-014 SHALL have port lo  output  XLEN  LO register (product lower half / quotient).

Function
REQ-015 SHALL implement the state machine IDLE -> CALC -> FIX -> IDLE; no other states are reachable.
REQ-016 SHALL, in IDLE with start=1 in cycle T, capture op and operands on the edge ending T: enter CALC, set busy=1, load the iteration counter with XLEN.
REQ-017 SHALL, for signed ops, convert operands to magnitudes at capture and record the result signs (product: sign A XOR sign B; quotient: sign A XOR sign B; remainder: sign A).
REQ-018 SHALL perform one shift-add multiply step or one restoring-divide step per CALC cycle, for exactly XLEN cycles (T+1..T+32), then enter FIX.
REQ-019 SHALL, in FIX (cycle T+33), apply two's-complement sign correction; on the edge ending T+33 it SHALL write hi/lo, set done=1 and busy=0, and return to IDLE.
REQ-020 SHALL hold done high for exactly cycle T+34 only; a start in T+34 SHALL be accepted (back-to-back issue period of 34 cycles).
REQ-021 SHALL leave hi/lo unchanged during CALC and FIX; intermediate values SHALL live in internal registers only.
REQ-022 SHALL ignore start while busy=1; the in-flight operation and its operands are unaffected.
REQ-023 SHALL produce a 64-bit product split as {hi,lo}; MULT is signed, MULTU unsigned.
REQ-024 SHALL truncate the quotient toward zero and give the remainder the sign of the dividend; DIVU is unsigned.
REQ-025 SHALL, on divide by zero (both DIV and DIVU), produce lo=32'hFFFFFFFF and hi=rs_data as captured, with normal latency.
REQ-026 SHALL, on DIV of 32'h80000000 by 32'hFFFFFFFF, produce lo=32'h80000000 and hi=0, with no error indication.
REQ-027 SHALL, in IDLE with start=0, write wdata to hi on hi_we and/or to lo on lo_we on the next edge; both strobes together SHALL write both.
REQ-028 SHALL ignore hi_we/lo_we while busy=1 and in the cycle in which start is accepted (start has priority).

Reset
REQ-029 SHALL, when rst=0, immediately and asynchronously set state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and internal operands.
REQ-030 SHALL, if reset is asserted mid-operation, abandon that operation; no done pulse and no hi/lo update SHALL follow after rst returns to 1.
REQ-031 SHALL accept start in the first cycle after rst deasserts.

Verification
REQ-032 SHALL verify: MULTU rs=32'hFFFFFFFF rt=32'h00000002 -> busy for cycles T+1..T+33, done in T+34, hi=32'h00000001, lo=32'hFFFFFFFE.
REQ-033 SHALL verify: MULT rs=-3 (32'hFFFFFFFD) rt=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; then DIV rs=-7 rt=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-034 SHALL verify: DIVU rs=100 rt=0 -> lo=32'hFFFFFFFF, hi=100; DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-035 SHALL verify: second start with different operands at T+10 -> ignored, result matches first op only; start at T+34 -> accepted, done at T+68.
REQ-036 SHALL verify: hi_we=1, wdata=32'h12345678 in IDLE -> hi=32'h12345678 next cycle; lo_we during busy -> lo unchanged; hi_we together with start -> hi unchanged.
REQ-037 SHALL verify: rst=0 at T+15 of a MULTU -> busy=0, hi=lo=0 immediately; no done pulse afterwards; new start after rst=1 completes normally.
